// File: rtl/insn_assembler_pkg.sv
// a3_ctl_pkg: opcodes, state encoding and widths shared between the
// instruction assembler and the control unit.
package a3_ctl_pkg;
    localparam logic [7:0] CTL_NOP      = 8'h00;
    localparam logic [7:0] CTL_LOAD_IMM = 8'h01;
    localparam int REG_W     = 6;
    localparam int IMM_W     = 64;
    localparam int IMM_BYTES = IMM_W / 8;
    typedef enum logic [1:0] {S_OP, S_REG, S_IMM, S_ISSUE} state_t;
endpackage

// File: rtl/insn_assembler_if.sv
// insn_assembler_if: byte-stream input and control-unit issue port of the assembler.
interface insn_assembler_if import a3_ctl_pkg::*; ();
    logic [7:0]       bus_in;
    logic             bus_valid;
    logic             bus_ready;
    logic             ctl_ready;
    logic [7:0]       ctl_op;
    logic [REG_W-1:0] reg_sel;
    logic [IMM_W-1:0] data_in;
    logic             err_illegal;
    logic             err_bad_reg;
    logic [15:0]      insn_count;
    modport slave (
        input  bus_in, bus_valid, ctl_ready,
        output bus_ready, ctl_op, reg_sel, data_in, err_illegal, err_bad_reg, insn_count
    );
    modport master (
        output bus_in, bus_valid, ctl_ready,
        input  bus_ready, ctl_op, reg_sel, data_in, err_illegal, err_bad_reg, insn_count
    );
endinterface

// File: rtl/insn_assembler.sv
// insn_assembler: assembles opcode/register/8-byte-immediate streams into
// one-cycle LOAD_IMM pulses for the control unit.
module insn_assembler import a3_ctl_pkg::*; (
    input logic              clk,
    input logic              rst,
    insn_assembler_if.slave  bus
);
    state_t           state;
    logic [2:0]       cnt;
    logic [REG_W-1:0] reg_hold;
    logic [IMM_W-1:0] imm;
    logic             take;

    assign bus.bus_ready = !rst && state != S_ISSUE;
    assign take = bus.bus_valid && bus.bus_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_OP;
            cnt             <= '0;
            reg_hold        <= '0;
            imm             <= '0;
            bus.ctl_op      <= CTL_NOP;
            bus.reg_sel     <= '0;
            bus.data_in     <= '0;
            bus.err_illegal <= 1'b0;
            bus.err_bad_reg <= 1'b0;
            bus.insn_count  <= '0;
        end else begin
            bus.ctl_op      <= CTL_NOP;
            bus.err_illegal <= 1'b0;
            bus.err_bad_reg <= 1'b0;
            case (state)
                S_OP: if (take) begin
                    if (bus.bus_in == CTL_LOAD_IMM) state <= S_REG;
                    else if (bus.bus_in != CTL_NOP) bus.err_illegal <= 1'b1;
                end
                S_REG: if (take) begin
                    if (|bus.bus_in[7:6]) begin
                        bus.err_bad_reg <= 1'b1;
                        state           <= S_OP;
                    end else begin
                        reg_hold <= bus.bus_in[REG_W-1:0];
                        imm      <= '0;
                        cnt      <= '0;
                        state    <= S_IMM;
                    end
                end
                S_IMM: if (take) begin
                    // little-endian: byte k lands in imm[8k+7:8k]
                    imm[{cnt, 3'b000} +: 8] <= bus.bus_in;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(IMM_BYTES - 1)) state <= S_ISSUE;
                end
                S_ISSUE: if (bus.ctl_ready) begin
                    bus.ctl_op     <= CTL_LOAD_IMM;
                    bus.reg_sel    <= reg_hold;
                    bus.data_in    <= imm;
                    bus.insn_count <= bus.insn_count + 16'd1;
                    state          <= S_OP;
                end
                default: state <= S_OP;
            endcase
        end
    end
endmodule

// File: tb/tb_insn_assembler.sv
// tb_insn_assembler: directed byte streams with hand-computed expectations.
module tb_insn_assembler;
    import a3_ctl_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    insn_assembler_if ifc();
    insn_assembler dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    int total = 0, bad = 0;
    int cyc = 0, n_issue, n_ill, n_bad, n_rdy_low, n_clash, issue_cyc, last_acc, start;
    logic [5:0]  last_reg;
    logic [63:0] last_data;
    logic [7:0]  seq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        n_issue = 0; n_ill = 0; n_bad = 0; n_rdy_low = 0; n_clash = 0; issue_cyc = -1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (ifc.ctl_op == 8'h01) begin
            n_issue++;
            issue_cyc = cyc;
            last_reg  = ifc.reg_sel;
            last_data = ifc.data_in;
            if (ifc.err_illegal || ifc.err_bad_reg) n_clash++;
        end
        if (ifc.err_illegal) n_ill++;
        if (ifc.err_bad_reg) n_bad++;
        if (!ifc.bus_ready) n_rdy_low++;
    endtask

    task automatic send_seq();
        bit acc;
        int w;
        for (int i = 0; i < seq.size(); i++) begin
            ifc.bus_in    = seq[i];
            ifc.bus_valid = 1'b1;
            w = 0;
            do begin
                acc = ifc.bus_ready;
                step();
                w++;
            end while (!acc && w < 50);
            if (!acc) check("accept_timeout", 0, 1);
            last_acc = cyc;
        end
    endtask

    task automatic idle(input int n);
        ifc.bus_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        ifc.bus_in = 8'h00; ifc.bus_valid = 1'b0; ifc.ctl_ready = 1'b1;
        clear();
        step(); step();
        check("rst_ctl_op", ifc.ctl_op, 8'h00);
        check("rst_reg_sel", ifc.reg_sel, 0);
        check("rst_data_in", ifc.data_in, 0);
        check("rst_count", ifc.insn_count, 0);
        check("rst_errs", {ifc.err_illegal, ifc.err_bad_reg}, 0);
        check("rst_ready_low", ifc.bus_ready, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", ifc.bus_ready, 1);

        // basic stream, valid held high
        clear(); start = cyc;
        seq = '{8'h01, 8'h05, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        send_seq();
        idle(3);
        check("t1_issues", n_issue, 1);
        check("t1_reg", last_reg, 5);
        check("t1_data", last_data, 64'h0123456789ABCDEF);
        check("t1_count", ifc.insn_count, 1);
        check("t1_latency", issue_cyc - last_acc, 1);
        check("t1_period", issue_cyc - start, 11);
        check("t1_ready_low", n_rdy_low, 1);
        check("t1_nop_after", ifc.ctl_op, 8'h00);

        // 3-cycle bubble after byte 4
        clear(); start = cyc;
        seq = '{8'h01, 8'h05, 8'hEF, 8'hCD, 8'hAB};
        send_seq();
        idle(3);
        seq = '{8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        send_seq();
        idle(3);
        check("t2_issues", n_issue, 1);
        check("t2_data", last_data, 64'h0123456789ABCDEF);
        check("t2_reg", last_reg, 5);
        check("t2_period", issue_cyc - start, 14);
        check("t2_count", ifc.insn_count, 2);

        // NOPs, illegal opcode, then reg 63
        clear();
        seq = '{8'h00, 8'h00, 8'h7F, 8'h01, 8'h3F};
        repeat (8) seq.push_back(8'h11);
        send_seq();
        idle(3);
        check("t3_illegal", n_ill, 1);
        check("t3_badreg", n_bad, 0);
        check("t3_issues", n_issue, 1);
        check("t3_reg", last_reg, 63);
        check("t3_data", last_data, 64'h1111111111111111);
        check("t3_count", ifc.insn_count, 3);

        // bad register byte aborts, next 01 starts fresh
        clear();
        seq = '{8'h01, 8'hC2};
        send_seq();
        idle(2);
        check("t4_badreg", n_bad, 1);
        check("t4_no_issue", n_issue, 0);
        seq = '{8'h01, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        send_seq();
        idle(3);
        check("t4_issues", n_issue, 1);
        check("t4_reg", last_reg, 2);
        check("t4_data", last_data, 64'h8070605040302010);
        check("t4_count", ifc.insn_count, 4);

        // control unit stalls the issue for 5 cycles
        clear();
        ifc.ctl_ready = 1'b0;
        seq = '{8'h01, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_seq();
        ifc.bus_in = 8'h01;
        repeat (5) step();
        check("t5_held_nop", ifc.ctl_op, 8'h00);
        check("t5_held_ready", ifc.bus_ready, 0);
        check("t5_no_issue", n_issue, 0);
        ifc.ctl_ready = 1'b1;
        step();
        check("t5_issue_op", ifc.ctl_op, 8'h01);
        check("t5_data", ifc.data_in, 64'h0807060504030201);
        idle(1);
        seq = '{8'h01, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_seq();
        idle(3);
        check("t5_next_reg", last_reg, 7);
        check("t5_next_data", last_data, 64'h0);
        check("t5_issues", n_issue, 2);
        check("t5_count", ifc.insn_count, 6);

        // reset after immediate byte 3
        clear();
        seq = '{8'h01, 8'h05, 8'hEF, 8'hCD, 8'hAB, 8'h89};
        send_seq();
        ifc.bus_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_ctl_op", ifc.ctl_op, 8'h00);
        check("t6_reg_sel", ifc.reg_sel, 0);
        check("t6_data_in", ifc.data_in, 0);
        check("t6_count", ifc.insn_count, 0);
        idle(2);
        check("t6_no_issue", n_issue, 0);
        check("t6_no_err", n_ill + n_bad, 0);
        seq = '{8'h01, 8'h09, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_seq();
        idle(3);
        check("t6_issues", n_issue, 1);
        check("t6_reg", last_reg, 9);
        check("t6_data", last_data, 64'h5A);
        check("t6_count2", ifc.insn_count, 1);
        check("no_err_with_issue", n_clash, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
